// File: rtl/dcache_pkg.sv
// Shared widths, state encoding and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int BLOCK_W  = 8 << OFFSET_W;
  localparam int MADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_e;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef logic [BLOCK_W-1:0]  block_t;

  function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic index_t addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic offset_t addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Line storage: valid/dirty flags (async cleared), tags and data blocks with one
// combinational read port, a byte-write port (cpu store hit) and a block-write port (refill).
module dcache_store
  import dcache_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  index_t  rd_index_i,
  output logic    rd_valid_o,
  output logic    rd_dirty_o,
  output tag_t    rd_tag_o,
  output block_t  rd_line_o,
  input  logic    byte_we_i,
  input  index_t  byte_index_i,
  input  offset_t byte_offset_i,
  input  logic [7:0] byte_data_i,
  input  logic    blk_we_i,
  input  index_t  blk_index_i,
  input  tag_t    blk_tag_i,
  input  block_t  blk_data_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  tag_t             tag_q  [LINES];
  block_t           data_q [LINES];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (blk_we_i) begin
        valid_q[blk_index_i] <= 1'b1;
        dirty_q[blk_index_i] <= 1'b0;
      end
      if (byte_we_i) dirty_q[byte_index_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; valid_q qualifies every use, so they can map to RAM.
  always_ff @(posedge clk) begin
    if (blk_we_i) begin
      tag_q[blk_index_i]  <= blk_tag_i;
      data_q[blk_index_i] <= blk_data_i;
    end
    if (byte_we_i) data_q[byte_index_i][{byte_offset_i, 3'b000} +: 8] <= byte_data_i;
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back/write-allocate data cache: hit logic, miss FSM and the
// block handshake towards data memory. The cpu is stalled only while a miss is serviced.
module dcache
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [7:0]         writedata_i,
  output logic [7:0]         readdata_o,
  output logic               busywait_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [MADDR_W-1:0] mem_address_o,
  output block_t             mem_writedata_o,
  input  block_t             mem_readdata_i,
  input  logic               mem_busywait_i
);

  state_e state_q, state_d;
  tag_t   miss_tag_q, miss_tag_d;
  index_t miss_index_q, miss_index_d;
  block_t fill_q, fill_d;
  logic   armed_q, armed_d;

  logic   req, hit, idle_hit, mem_done;
  index_t rd_index;
  logic   st_valid, st_dirty;
  tag_t   st_tag;
  block_t st_line;

  assign req      = read_i | write_i;
  assign rd_index = (state_q == S_IDLE) ? addr_index(address_i) : miss_index_q;

  dcache_store u_store (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_index_i    (rd_index),
    .rd_valid_o    (st_valid),
    .rd_dirty_o    (st_dirty),
    .rd_tag_o      (st_tag),
    .rd_line_o     (st_line),
    .byte_we_i     (idle_hit & write_i),
    .byte_index_i  (addr_index(address_i)),
    .byte_offset_i (addr_offset(address_i)),
    .byte_data_i   (writedata_i),
    .blk_we_i      (state_q == S_UPDATE),
    .blk_index_i   (miss_index_q),
    .blk_tag_i     (miss_tag_q),
    .blk_data_i    (fill_q)
  );

  assign hit        = st_valid && (st_tag == addr_tag(address_i));
  assign idle_hit   = (state_q == S_IDLE) && hit && req;
  assign busywait_o = req && !idle_hit;
  assign readdata_o = idle_hit ? st_line[{addr_offset(address_i), 3'b000} +: 8] : 8'h00;

  // The memory's busy flag is only trusted after the request has been up for one edge.
  assign mem_done = armed_q && !mem_busywait_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    state_d         = state_q;
    miss_tag_d      = miss_tag_q;
    miss_index_d    = miss_index_q;
    fill_d          = fill_q;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_address_o   = '0;
    mem_writedata_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          miss_tag_d   = addr_tag(address_i);
          miss_index_d = addr_index(address_i);
          state_d      = st_dirty ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        mem_write_o     = 1'b1;
        mem_address_o   = {st_tag, miss_index_q};
        mem_writedata_o = st_line;
        if (mem_done) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_o    = 1'b1;
        mem_address_o = {miss_tag_q, miss_index_q};
        if (mem_done) begin
          fill_d  = mem_readdata_i;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    armed_d = ((state_q == S_WRITEBACK) || (state_q == S_FETCH)) && (state_d == state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      fill_q       <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Randomized bench for dcache: a flat byte-memory view plus a tag/valid/dirty directory
// predict stalls, memory traffic and load data; a 5-cycle block memory serves misses.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_i, write_i;
  logic [7:0]  address_i, writedata_i;
  logic [7:0]  readdata_o;
  logic        busywait_o, mem_read_o, mem_write_o;
  logic [5:0]  mem_address_o;
  logic [31:0] mem_writedata_o;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  int errors = 0;
  int checks = 0;

  dcache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read_i          (read_i),
    .write_i         (write_i),
    .address_i       (address_i),
    .writedata_i     (writedata_i),
    .readdata_o      (readdata_o),
    .busywait_o      (busywait_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .mem_address_o   (mem_address_o),
    .mem_writedata_o (mem_writedata_o),
    .mem_readdata_i  (mem_rdata),
    .mem_busywait_i  (mem_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int i);
    return {8'(i * 31 + 4), 8'(i * 29 + 3), 8'(i * 13 + 2), 8'(i * 7 + 1)};
  endfunction

  // Behavioural block memory: busy for 5 edges after it sees a request, then one idle edge.
  logic [31:0] mem_arr [64];
  int          cnt, wb_cnt, fetch_cnt;
  logic        cool, init_done = 1'b0;
  logic [5:0]  last_wb_addr, last_fetch_addr;
  logic [31:0] last_wb_data;

  initial begin
    wb_cnt = 0;
    fetch_cnt = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy <= 1'b0;
      cnt      <= 0;
      cool     <= 1'b0;
      if (!init_done) begin
        for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
        mem_rdata <= '0;
        init_done <= 1'b1;
      end
    end else if (cool) begin
      cool <= 1'b0;
    end else if (cnt == 0) begin
      if (mem_read_o || mem_write_o) begin
        cnt      <= 5;
        mem_busy <= 1'b1;
      end
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else begin
      cnt      <= 0;
      mem_busy <= 1'b0;
      cool     <= 1'b1;
      if (mem_write_o) begin
        mem_arr[mem_address_o] <= mem_writedata_o;
        wb_cnt       <= wb_cnt + 1;
        last_wb_addr <= mem_address_o;
        last_wb_data <= mem_writedata_o;
      end else begin
        mem_rdata       <= mem_arr[mem_address_o];
        fetch_cnt       <= fetch_cnt + 1;
        last_fetch_addr <= mem_address_o;
      end
    end
  end

  // Reference: what the cpu should see (flat) and which blocks the cache holds.
  logic [7:0] flat [256];
  logic       mvalid [8];
  logic       mdirty [8];
  logic [2:0] mtag   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d);
    logic [2:0]  idx, tag;
    bit          hit, wb;
    int          wb0, f0, cyc;
    logic [31:0] victim;
    idx = a[4:2];
    tag = a[7:5];
    hit = mvalid[idx] && (mtag[idx] == tag);
    wb  = !hit && mvalid[idx] && mdirty[idx];
    wb0 = wb_cnt;
    f0  = fetch_cnt;
    cyc = 0;
    victim = {flat[{mtag[idx], idx, 2'd3}], flat[{mtag[idx], idx, 2'd2}],
              flat[{mtag[idx], idx, 2'd1}], flat[{mtag[idx], idx, 2'd0}]};
    @(posedge clk);
    #1;
    read_i = rd; write_i = wr; address_i = a; writedata_i = d;
    @(negedge clk);
    check("stall", 32'(busywait_o), 32'(!hit));
    while (busywait_o && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (busywait_o) check("timeout", 32'(busywait_o), 32'd0);
    if (rd && !wr) check("rdata", 32'(readdata_o), 32'(flat[a]));
    check("wb_cnt", 32'(wb_cnt - wb0), 32'(wb));
    check("fetch_cnt", 32'(fetch_cnt - f0), 32'(!hit));
    if (wb) begin
      check("wb_addr", 32'(last_wb_addr), 32'({mtag[idx], idx}));
      check("wb_data", last_wb_data, victim);
    end
    if (!hit) check("fetch_addr", 32'(last_fetch_addr), 32'({tag, idx}));
    @(posedge clk);
    if (rd && wr) begin
      @(negedge clk);
      check("rw_rdata", 32'(readdata_o), 32'(d));
    end
    #1;
    read_i = 1'b0; write_i = 1'b0;
    if (!hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      flat[a]     = d;
      mdirty[idx] = 1'b1;
    end
  endtask

  task automatic resync_after_reset();
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    for (int i = 0; i < 256; i++) begin
      w = mem_arr[i >> 2];
      flat[i] = w[8 * (i % 4) +: 8];
    end
  endtask

  initial begin
    logic [31:0] w;
    int          cyc;
    bit          wsel;
    rst_n = 1'b0;
    read_i = 1'b0; write_i = 1'b0; address_i = '0; writedata_i = '0;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i >> 2);
      flat[i] = w[8 * (i % 4) +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end
    #12;
    check("rst_busywait", 32'(busywait_o), 32'd0);
    check("rst_readdata", 32'(readdata_o), 32'd0);
    check("rst_mem_read", 32'(mem_read_o), 32'd0);
    check("rst_mem_write", 32'(mem_write_o), 32'd0);
    check("rst_mem_addr", 32'(mem_address_o), 32'd0);
    check("rst_mem_wdata", mem_writedata_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 8'h05, 8'h00);
    access(1'b1, 1'b0, 8'h06, 8'hAA);
    access(1'b0, 1'b1, 8'h06, 8'h00);
    access(1'b0, 1'b1, 8'h26, 8'h00);
    check("dir_wb_addr", 32'(last_wb_addr), 32'h01);
    check("dir_wb_byte2", 32'(last_wb_data[23:16]), 32'hAA);
    check("dir_fetch_addr", 32'(last_fetch_addr), 32'h09);
    access(1'b0, 1'b1, 8'h05, 8'h00);
    access(1'b1, 1'b1, 8'h05, 8'h3C);

    // Miss on a dirty line, then reset while the refill is outstanding.
    @(posedge clk);
    #1;
    read_i = 1'b1; address_i = 8'h45;
    cyc = 0;
    while (!mem_read_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_fetch_seen", 32'(mem_read_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    read_i = 1'b0;
    #1;
    check("midrst_mem_read", 32'(mem_read_o), 32'd0);
    check("midrst_busywait", 32'(busywait_o), 32'd0);
    check("midrst_mem_addr", 32'(mem_address_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resync_after_reset();
    access(1'b0, 1'b1, 8'h45, 8'h00);

    for (int n = 0; n < 200; n++) begin
      wsel = 1'($urandom_range(0, 1));
      access(wsel, !wsel, 8'($urandom_range(0, 255)) & 8'h7F, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
